// File: rtl/img_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : img_pkg                                                  |
// | Purpose   : Shared frame geometry, pixel packing and FSM encodings   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package img_pkg;

    localparam int DEF_WIDTH  = 800;
    localparam int DEF_HEIGHT = 600;
    localparam int DEF_SIZE   = DEF_WIDTH * DEF_HEIGHT;
    localparam int DEF_CH_W   = 8;
    localparam int DEF_NCH    = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tap3_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tap3_channel                                             |
// | Purpose   : Combinational [1 2 1]/4 smoothing for one colour channel |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tap3_channel #(
    parameter int CH_W = 8
) (
    input  logic [CH_W-1:0] l,
    input  logic [CH_W-1:0] c,
    input  logic [CH_W-1:0] r,
    output logic [CH_W-1:0] y
);

    logic [CH_W+1:0] w_sum;

    // Two guard bits hold the worst case 4*(2^CH_W-1); the shift floors.
    assign w_sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r};
    assign y     = CH_W'(w_sum >> 2);

endmodule
`default_nettype wire

// File: rtl/row_smooth_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : row_smooth_filter                                        |
// | Purpose   : Streamed horizontal 3-tap RGB smoother with edge replicate|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module row_smooth_filter
    import img_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int CH_W   = DEF_CH_W,
    parameter int NCH    = DEF_NCH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [NCH*CH_W-1:0] in_pixel,
    output logic                out_valid,
    output logic [NCH*CH_W-1:0] out_pixel,
    output logic [31:0]         out_addr,
    output logic                busy,
    output logic                done
);

    localparam int          PIX_W     = NCH * CH_W;
    localparam int          COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int          ROW_W     = $clog2(HEIGHT + 1);
    localparam logic [31:0] LAST_ADDR = 32'(WIDTH * HEIGHT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [31:0]        r_emit_cnt;
    logic [PIX_W-1:0]   r_prev1;
    logic [PIX_W-1:0]   r_prev2;
    logic [PIX_W-1:0]   w_l;
    logic [PIX_W-1:0]   w_c;
    logic [PIX_W-1:0]   w_r;
    logic [PIX_W-1:0]   w_y;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_flush;
    logic               w_accept;
    logic               w_emit;
    logic               w_launch;

    assign w_last_col = (r_col == COL_W'(WIDTH - 1));
    // r_row has already advanced past the final row by the time S_FLUSH runs.
    assign w_last_row = (r_row == ROW_W'(HEIGHT));
    assign w_flush    = (r_state == S_FLUSH);
    assign w_accept   = in_valid && ((r_state == S_RUN) || (w_flush && !w_last_row));
    assign w_emit     = w_flush || (w_accept && (r_col != '0));
    assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_col) w_next = S_FLUSH;
            S_FLUSH: w_next = w_last_row ? S_DONE : S_RUN;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // Window taps: flush replicates the right edge, column 1 replicates the left.
    always_comb begin
        w_c = r_prev1;
        w_l = r_prev2;
        w_r = in_pixel;
        if (w_flush) begin
            w_r = r_prev1;
        end else if (r_col == COL_W'(1)) begin
            w_l = r_prev1;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        tap3_channel #(
            .CH_W (CH_W)
        ) u_tap (
            .l (w_l[ch*CH_W +: CH_W]),
            .c (w_c[ch*CH_W +: CH_W]),
            .r (w_r[ch*CH_W +: CH_W]),
            .y (w_y[ch*CH_W +: CH_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_emit_cnt <= '0;
            r_prev1    <= '0;
            r_prev2    <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            out_valid <= w_emit;
            if (w_emit) begin
                out_pixel  <= w_y;
                out_addr   <= r_emit_cnt;
                r_emit_cnt <= r_emit_cnt + 32'd1;
                if (r_emit_cnt == LAST_ADDR) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
            if (w_launch) begin
                r_col      <= '0;
                r_row      <= '0;
                r_emit_cnt <= '0;
                r_prev1    <= '0;
                r_prev2    <= '0;
                done       <= 1'b0;
                busy       <= 1'b1;
            end else if (w_accept) begin
                r_prev2 <= r_prev1;
                r_prev1 <= in_pixel;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
